mux_nto1_pipe: RTL and testbench
================================

# mux_nto1_pipe

Parametrised, registered N-to-1 multiplexer with dual-rail select checking, a valid/ready output stage and an auto-scan mode. It is the next generation of the 1-bit 8-to-1 mux in the digital parts library. It adds width and channel-count parameters, a pipelined handshake, and sticky detection of illegal select codes, so it can sit directly between a bank of data sources and a single downstream consumer.

## Interface
Parameters:
- WIDTH, 1, bits per channel
- CHANNELS, 8, number of input channels, 2..256
- SEL_W, 3, select width; must equal clog2(CHANNELS)

Ports:
- Clk  in  1  clock, rising edge
- _Reset  in  1  asynchronous, active-low reset
- In  in  CHANNELS*WIDTH  flat input bus; channel k is at bits [k*WIDTH +: WIDTH]
- Select  in  SEL_W  channel select, true rail
- _Select  in  SEL_W  channel select, complement rail
- Mode  in  1  0 = SELECT (rails choose the channel), 1 = SCAN (internal pointer chooses the channel)
- InValid  in  1  request to sample a channel
- InReady  out  1  block can accept a request this cycle
- Out  out  WIDTH  registered selected data
- OutChannel  out  SEL_W  channel index that produced Out
- OutValid  out  1  Out/OutChannel hold valid data
- OutReady  in  1  consumer accepts Out
- SelError  out  1  sticky illegal-select flag
- ClearError  in  1  clears SelError

## Operation
- InReady = !OutValid || OutReady, combinational. A request is accepted when InValid && InReady.
- Output stage has two states:
  - EMPTY (OutValid=0)
  - FULL (OutValid=1)
- Transitions:
  - EMPTY→FULL on a good accept.
  - FULL→FULL on a good accept while OutReady is high.
  - FULL→EMPTY when OutReady is high and there is no good accept.
  - FULL holds Out, OutChannel and OutValid while OutReady is low.
- SELECT mode: a code is good only if Select == ~_Select and Select < CHANNELS.
  - Good accept: Out ← In[Select], OutChannel ← Select.
  - Bad accept: the request is still consumed, no data is captured, and SelError sets. The stage follows the no-good-accept transition.
- SCAN mode: the rails are ignored and never raise an error.
  - Accept captures In[ScanPtr], OutChannel ← ScanPtr, then ScanPtr increments.
  - ScanPtr wraps from CHANNELS-1 to 0.
- Mode is sampled every cycle, and the mode in effect on the accept cycle governs that accept.
  - A registered 0→1 Mode edge resets ScanPtr to 0 before that cycle's accept.
  - SELECT accepts do not change ScanPtr.
- SelError stays set until a cycle with ClearError high and no new error. If a new error and ClearError occur in the same cycle, the error wins.

## Timing
- Reset values: Out=0, OutChannel=0, OutValid=0, SelError=0, ScanPtr=0, state EMPTY. InReady therefore reads 1 during reset.
- Reset is asynchronous. Assertion mid-transfer drops OutValid immediately and the pending word is lost.
- Latency: a request accepted at edge n gives OutValid and data at edge n, visible in cycle n+1.
- Throughput: 1 word per cycle while OutReady is held high.
- When OutValid=1 and OutReady=0: InReady=0, and Out/OutChannel must be stable until the handshake completes.
- In, Select and _Select are sampled only on the accept edge. No assumption is made about them in other cycles.

## Structure
- Package mux_pkg holds:
  - clog2 function
  - MODE_SELECT / MODE_SCAN constants
  - state encoding EMPTY/FULL
- Sub-module mux_sel_check: combinational dual-rail check and range check. Outputs `good` and the decoded index; it is parametrised by SEL_W and CHANNELS.
- Top level holds the output register, state, ScanPtr and the SelError logic.

## Test plan
- WIDTH=8, CHANNELS=8, SELECT mode. Select=3, _Select=4, In[3]=8'hA5, InValid=1, OutReady=1 → next cycle Out=8'hA5, OutChannel=3, OutValid=1.
- Rail mismatch: Select=2, _Select=2 → SelError=1, Out unchanged, OutValid=0. ClearError pulse → SelError=0.
- CHANNELS=6, Select=7, _Select=0 → out of range: SelError=1, no capture.
- SCAN mode, InValid and OutReady held high for 14 cycles → OutChannel sequence 0,1,…,5,0,…,5,0,1. Data matches each channel.
- Backpressure: hold OutReady=0 after a good accept → InReady=0, Out stable for 5 cycles. Release OutReady → a queued request is accepted that same cycle.
- Assert _Reset low while FULL → OutValid, Out, OutChannel and SelError go to 0 without waiting for a clock edge. ScanPtr restarts at 0.

Source files
------------

// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the pipelined N-to-1 multiplexer:
//   - clog2 helper used to size the select rails
//   - MODE_SELECT / MODE_SCAN values of the Mode input
//   - output-stage state encoding (EMPTY / FULL)
// ---------------------------------------------------------------------------
package mux_pkg;

   // Values of the Mode input
   localparam logic MODE_SELECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Output stage: EMPTY means OutValid=0, FULL means OutValid=1
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   // Number of bits needed to index n items (clog2(1) = 0)
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned v;
      int unsigned r;
      v = (n > 0) ? n - 1 : 0;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if (v != 0) begin
            r = r + 1;
            v = v >> 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_sel_check.sv
// ---------------------------------------------------------------------------
// mux_sel_check
// Combinational validation of a dual-rail channel select.
// A code is good only when the complement rail is the exact inverse of the
// true rail and the decoded index names an existing channel.
//
// Ports:
//   sel    in  SEL_W  true rail
//   sel_n  in  SEL_W  complement rail
//   good   out 1      rails consistent and index < CHANNELS
//   idx    out SEL_W  decoded channel index (meaningful only when good)
// ---------------------------------------------------------------------------
module mux_sel_check
   import mux_pkg::*;
#(
   parameter int unsigned SEL_W    = 3,
   parameter int unsigned CHANNELS = 8
) (
   input  logic [SEL_W-1:0] sel,
   input  logic [SEL_W-1:0] sel_n,
   output logic             good,
   output logic [SEL_W-1:0] idx
);

   logic rails_ok;
   logic in_range;

   // Any bit where both rails agree indicates a stuck or crossed wire
   assign rails_ok = (sel == ~sel_n);

   // Only matters when CHANNELS is not a power of two
   assign in_range = (32'(sel) < CHANNELS);

   assign good = rails_ok && in_range;
   assign idx  = sel;

endmodule

// File: rtl/mux_nto1_pipe.sv
// ---------------------------------------------------------------------------
// mux_nto1_pipe
// Registered N-to-1 multiplexer with a valid/ready output stage, dual-rail
// select checking with a sticky error flag, and an auto-scan mode that
// walks the channels in order.
//
// Ports:
//   Clk         in  1               clock, rising edge
//   _Reset      in  1               asynchronous active-low reset
//   In          in  CHANNELS*WIDTH  flat input bus, channel k at [k*WIDTH +: WIDTH]
//   Select      in  SEL_W           channel select, true rail
//   _Select     in  SEL_W           channel select, complement rail
//   Mode        in  1               0 = SELECT, 1 = SCAN
//   InValid     in  1               request to sample a channel
//   InReady     out 1               request can be accepted (combinational)
//   Out         out WIDTH           registered selected data
//   OutChannel  out SEL_W           channel that produced Out
//   OutValid    out 1               Out/OutChannel valid
//   OutReady    in  1               consumer accepts Out
//   SelError    out 1               sticky illegal-select flag
//   ClearError  in  1               clears SelError (a same-cycle new error wins)
// ---------------------------------------------------------------------------
module mux_nto1_pipe
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH    = 1,
   parameter int unsigned CHANNELS = 8,
   parameter int unsigned SEL_W    = clog2(CHANNELS)
) (
   input  logic                      Clk,
   input  logic                      _Reset,
   input  logic [CHANNELS*WIDTH-1:0] In,
   input  logic [SEL_W-1:0]          Select,
   input  logic [SEL_W-1:0]          _Select,
   input  logic                      Mode,
   input  logic                      InValid,
   output logic                      InReady,
   output logic [WIDTH-1:0]          Out,
   output logic [SEL_W-1:0]          OutChannel,
   output logic                      OutValid,
   input  logic                      OutReady,
   output logic                      SelError,
   input  logic                      ClearError
);

   localparam int unsigned LAST_CH = CHANNELS - 1;

   state_t             state;
   logic               mode_q;
   logic [SEL_W-1:0]   scan_ptr;

   logic               sel_good;
   logic [SEL_W-1:0]   sel_idx;
   logic               scan_mode;
   logic               scan_edge;
   logic [SEL_W-1:0]   eff_ptr;
   logic [SEL_W-1:0]   next_ptr;
   logic [SEL_W-1:0]   cap_idx;
   logic [WIDTH-1:0]   cap_data;
   logic               accept;
   logic               good_accept;
   logic               err_set;
   logic [WIDTH-1:0]   chan [CHANNELS];

   // Unpack the flat input bus into per-channel words
   for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
      assign chan[k] = In[k*WIDTH +: WIDTH];
   end

   // Dual-rail and range validation of the select code
   mux_sel_check #(
      .SEL_W    (SEL_W),
      .CHANNELS (CHANNELS)
   ) u_sel_check (
      .sel   (Select),
      .sel_n (_Select),
      .good  (sel_good),
      .idx   (sel_idx)
   );

   // Handshake: a full stage frees up in the same cycle it is drained
   assign OutValid = (state == FULL);
   assign InReady  = (state == EMPTY) || OutReady;
   assign accept   = InValid && InReady;

   // Entering SCAN restarts the walk at channel 0 for this very accept
   assign scan_mode = (Mode == MODE_SCAN);
   assign scan_edge = scan_mode && (mode_q == MODE_SELECT);
   assign eff_ptr   = scan_edge ? '0 : scan_ptr;
   assign next_ptr  = (eff_ptr == SEL_W'(LAST_CH)) ? '0 : eff_ptr + SEL_W'(1);

   // SCAN never raises an error; a bad SELECT request is consumed but dropped
   assign good_accept = accept && (scan_mode || sel_good);
   assign err_set     = accept && !scan_mode && !sel_good;

   assign cap_idx = scan_mode ? eff_ptr : sel_idx;

   // Channel mux; out-of-range indices never reach the capture path
   always_comb begin
      cap_data = '0;
      for (int k = 0; k < int'(CHANNELS); k++) begin
         if (cap_idx == SEL_W'(k)) begin
            cap_data = chan[k];
         end
      end
   end

   // Output stage FSM with its data/channel registers
   always_ff @(posedge Clk or negedge _Reset) begin
      if (!_Reset) begin
         state      <= EMPTY;
         Out        <= '0;
         OutChannel <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (good_accept) begin
                  state      <= FULL;
                  Out        <= cap_data;
                  OutChannel <= cap_idx;
               end
            end
            FULL: begin
               // An accept while FULL implies OutReady, so the word is replaced
               if (good_accept) begin
                  Out        <= cap_data;
                  OutChannel <= cap_idx;
               end else if (OutReady) begin
                  state <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   // Scan pointer and registered mode used for 0->1 edge detection
   always_ff @(posedge Clk or negedge _Reset) begin
      if (!_Reset) begin
         mode_q   <= MODE_SELECT;
         scan_ptr <= '0;
      end else begin
         mode_q <= Mode;
         if (good_accept && scan_mode) begin
            scan_ptr <= next_ptr;
         end else if (scan_edge) begin
            scan_ptr <= '0;
         end
      end
   end

   // Sticky select error; a new error beats a same-cycle clear
   always_ff @(posedge Clk or negedge _Reset) begin
      if (!_Reset) begin
         SelError <= 1'b0;
      end else if (err_set) begin
         SelError <= 1'b1;
      end else if (ClearError) begin
         SelError <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// ---------------------------------------------------------------------------
// tb_mux_nto1_pipe
// Self-checking bench for mux_nto1_pipe with WIDTH=8, CHANNELS=6, SEL_W=3.
// Expected words are queued when a request is driven and popped when the
// DUT presents the captured word.
// ---------------------------------------------------------------------------
module tb_mux_nto1_pipe;

   localparam int unsigned WIDTH    = 8;
   localparam int unsigned CHANNELS = 6;
   localparam int unsigned SEL_W    = 3;

   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic [SEL_W-1:0] c;
   } exp_t;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic [CHANNELS*WIDTH-1:0] in_bus;
   logic [SEL_W-1:0]          sel;
   logic [SEL_W-1:0]          sel_n;
   logic                      mode;
   logic                      in_valid;
   logic                      in_ready;
   logic [WIDTH-1:0]          out;
   logic [SEL_W-1:0]          out_ch;
   logic                      out_valid;
   logic                      out_ready;
   logic                      sel_error;
   logic                      clear_error;

   logic [WIDTH-1:0] ch_data [CHANNELS];
   exp_t             sbq [$];
   int               n_cmp = 0;
   int               n_err = 0;

   always #5 clk = ~clk;

   mux_nto1_pipe #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
   ) dut (
      .Clk        (clk),
      ._Reset     (rst_n),
      .In         (in_bus),
      .Select     (sel),
      ._Select    (sel_n),
      .Mode       (mode),
      .InValid    (in_valid),
      .InReady    (in_ready),
      .Out        (out),
      .OutChannel (out_ch),
      .OutValid   (out_valid),
      .OutReady   (out_ready),
      .SelError   (sel_error),
      .ClearError (clear_error)
   );

   task automatic set_ch(input int k, input logic [WIDTH-1:0] v);
      ch_data[k] = v;
      in_bus[k*WIDTH +: WIDTH] = v;
   endtask

   task automatic push_exp(input int k);
      exp_t e;
      e.d = ch_data[k];
      e.c = SEL_W'(k);
      sbq.push_back(e);
   endtask

   function automatic exp_t pop_exp();
      exp_t e;
      e.d = 'x;
      e.c = 'x;
      if (sbq.size() > 0) e = sbq.pop_front();
      return e;
   endfunction

   task automatic drive(input logic [SEL_W-1:0] s, input logic [SEL_W-1:0] sn,
                        input logic m, input logic v, input logic r, input logic c);
      @(negedge clk);
      sel         = s;
      sel_n       = sn;
      mode        = m;
      in_valid    = v;
      out_ready   = r;
      clear_error = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      sel         = '0;
      sel_n       = '1;
      mode        = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      clear_error = 1'b0;
      in_bus      = '0;
      for (int k = 0; k < int'(CHANNELS); k++) set_ch(k, WIDTH'($urandom));
      set_ch(3, 8'hA5);
      #12;
      n_cmp++; if (out !== 8'h00)    begin n_err++; $display("FAIL reset_out got=%h want=00", out); end
      n_cmp++; if (out_ch !== 3'd0)  begin n_err++; $display("FAIL reset_ch got=%0d want=0", out_ch); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      n_cmp++; if (sel_error !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b want=0", sel_error); end
      n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_ready got=%b want=1", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_select_good();
      exp_t e;
      drive(3'd3, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
      push_exp(3);
      tick();
      e = pop_exp();
      n_cmp++; if (out !== e.d)       begin n_err++; $display("FAIL sel_good_out got=%h want=%h", out, e.d); end
      n_cmp++; if (out_ch !== e.c)    begin n_err++; $display("FAIL sel_good_ch got=%0d want=%0d", out_ch, e.c); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sel_good_valid got=%b want=1", out_valid); end
      drive(3'd3, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sel_drain_valid got=%b want=0", out_valid); end
   endtask

   task automatic test_rail_mismatch();
      drive(3'd2, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      n_cmp++; if (sel_error !== 1'b1) begin n_err++; $display("FAIL rail_err got=%b want=1", sel_error); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rail_valid got=%b want=0", out_valid); end
      n_cmp++; if (out !== 8'hA5)      begin n_err++; $display("FAIL rail_out_hold got=%h want=a5", out); end
      // New error in the same cycle as a clear keeps the flag set
      drive(3'd2, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      n_cmp++; if (sel_error !== 1'b1) begin n_err++; $display("FAIL err_wins got=%b want=1", sel_error); end
      drive(3'd2, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      n_cmp++; if (sel_error !== 1'b0) begin n_err++; $display("FAIL err_clear got=%b want=0", sel_error); end
   endtask

   task automatic test_out_of_range();
      exp_t e;
      drive(3'd7, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      n_cmp++; if (sel_error !== 1'b1) begin n_err++; $display("FAIL oor7_err got=%b want=1", sel_error); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL oor7_valid got=%b want=0", out_valid); end
      n_cmp++; if (out !== 8'hA5)      begin n_err++; $display("FAIL oor7_out got=%h want=a5", out); end
      drive(3'd6, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      drive(3'd6, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      n_cmp++; if (sel_error !== 1'b1) begin n_err++; $display("FAIL oor6_err got=%b want=1", sel_error); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL oor6_valid got=%b want=0", out_valid); end
      // Highest legal channel is still accepted
      drive(3'd5, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1);
      push_exp(5);
      tick();
      e = pop_exp();
      n_cmp++; if (out !== e.d)    begin n_err++; $display("FAIL ch5_out got=%h want=%h", out, e.d); end
      n_cmp++; if (out_ch !== e.c) begin n_err++; $display("FAIL ch5_ch got=%0d want=%0d", out_ch, e.c); end
      n_cmp++; if (sel_error !== 1'b0) begin n_err++; $display("FAIL ch5_err got=%b want=0", sel_error); end
      drive(3'd5, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
   endtask

   task automatic test_scan();
      exp_t e;
      for (int i = 0; i < 14; i++) begin
         drive(3'd2, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
         push_exp(i % int'(CHANNELS));
         tick();
         e = pop_exp();
         n_cmp++; if (out_ch !== e.c || out !== e.d || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL scan_%0d got=%0d/%h/%b want=%0d/%h/1", i, out_ch, out, out_valid, e.c, e.d);
         end
      end
      n_cmp++; if (sel_error !== 1'b0) begin n_err++; $display("FAIL scan_no_err got=%b want=0", sel_error); end
      // Leaving and re-entering SCAN restarts the walk at channel 0
      drive(3'd2, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(3'd2, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
      push_exp(0);
      tick();
      e = pop_exp();
      n_cmp++; if (out_ch !== e.c || out !== e.d) begin
         n_err++; $display("FAIL scan_restart got=%0d/%h want=%0d/%h", out_ch, out, e.c, e.d);
      end
      drive(3'd2, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
   endtask

   task automatic test_backpressure();
      exp_t e;
      drive(3'd4, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      push_exp(4);
      tick();
      e = pop_exp();
      n_cmp++; if (out !== e.d || out_ch !== e.c) begin
         n_err++; $display("FAIL bp_capture got=%0d/%h want=%0d/%h", out_ch, out, e.c, e.d);
      end
      for (int i = 0; i < 5; i++) begin
         drive(3'd1, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0);
         set_ch(4, WIDTH'($urandom));
         set_ch(1, WIDTH'($urandom));
         tick();
         n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out !== e.d || out_ch !== e.c) begin
            n_err++;
            $display("FAIL bp_hold_%0d got=rdy%b v%b %0d/%h want=rdy0 v1 %0d/%h",
                     i, in_ready, out_valid, out_ch, out, e.c, e.d);
         end
      end
      drive(3'd1, 3'd6, 1'b0, 1'b1, 1'b1, 1'b0);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
      push_exp(1);
      tick();
      e = pop_exp();
      n_cmp++; if (out !== e.d || out_ch !== e.c || out_valid !== 1'b1) begin
         n_err++; $display("FAIL bp_queued got=%0d/%h want=%0d/%h", out_ch, out, e.c, e.d);
      end
      drive(3'd1, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got=%b want=0", out_valid); end
   endtask

   task automatic test_async_reset();
      exp_t e;
      drive(3'd2, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(3'd5, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      push_exp(5);
      tick();
      e = pop_exp();
      n_cmp++; if (out !== e.d || out_ch !== e.c || out_valid !== 1'b1 || sel_error !== 1'b1) begin
         n_err++; $display("FAIL ar_pre got=%0d/%h v%b e%b want=%0d/%h v1 e1",
                           out_ch, out, out_valid, sel_error, e.c, e.d);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || out !== 8'h00 || out_ch !== 3'd0 || sel_error !== 1'b0) begin
         n_err++; $display("FAIL ar_async got=%0d/%h v%b e%b want=0/00 v0 e0",
                           out_ch, out, out_valid, sel_error);
      end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ar_ready got=%b want=1", in_ready); end
      sbq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      sel = 3'd2; sel_n = 3'd2; mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1; clear_error = 1'b0;
      push_exp(0);
      tick();
      e = pop_exp();
      n_cmp++; if (out !== e.d || out_ch !== e.c || out_valid !== 1'b1) begin
         n_err++; $display("FAIL ar_scan0 got=%0d/%h want=%0d/%h", out_ch, out, e.c, e.d);
      end
      drive(3'd2, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
      push_exp(1);
      tick();
      e = pop_exp();
      n_cmp++; if (out !== e.d || out_ch !== e.c) begin
         n_err++; $display("FAIL ar_scan1 got=%0d/%h want=%0d/%h", out_ch, out, e.c, e.d);
      end
      drive(3'd2, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
   endtask

   initial begin
      test_reset();
      test_select_good();
      test_rail_mismatch();
      test_out_of_range();
      test_scan();
      test_backpressure();
      test_async_reset();
      n_cmp++; if (sbq.size() != 0) begin n_err++; $display("FAIL sb_leftover got=%0d want=0", sbq.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
